// File: rtl/iob_mem_arbiter.sv
// ---------------------------------------------------------------------------
// iob_mem_arbiter
//
// Purpose:
//    Shares a single memory port (the DDR path) between two IOb-style
//    requesters, m0 and m1. Only one transaction is outstanding at a time.
//    Round-robin arbitration picks the requester. Its request fields are
//    registered onto the shared port, and the slave's completion is routed
//    back to that requester. A watchdog counter forces completion of a
//    transaction the slave never answers and records that in a sticky flag.
//
// Parameters:
//    ADDR_W   address width of all ports
//    DATA_W   data width of all ports (strobes are DATA_W/8 bits)
//    TIMEOUT  max cycles the slave may take before forced completion (2..65535)
//
// Ports:
//    clk, reset                     rising-edge clock, synchronous active-high reset
//    m0_valid/addr/wdata/wstrb      requester 0 request (wstrb == 0 means read)
//    m0_rdata, m0_ready             requester 0 read data and completion pulse
//    m1_valid/addr/wdata/wstrb      requester 1 request
//    m1_rdata, m1_ready             requester 1 read data and completion pulse
//    s_valid, s_addr/wdata/wstrb    request to the shared slave (registered fields)
//    s_rdata, s_ready               slave read data and completion pulse
//    timeout_err                    sticky: a forced completion happened since reset
// ---------------------------------------------------------------------------
module iob_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                m0_valid,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_ready,

   input  logic                m1_valid,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_ready,

   output logic                s_valid,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic                s_ready,

   output logic                timeout_err
);

   // Last BUSY cycle index the slave is given before completion is forced.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t      state;
   state_t      state_next;

   // grant_m1 remembers who owns the outstanding transaction.
   // prio_m1 is the round-robin pointer: set when m1 should win a tie.
   logic        grant_m1;
   logic        prio_m1;
   logic [15:0] cycle_cnt;

   logic        pick_m1;
   logic        start;
   logic        done;
   logic        forced;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and all combinational outputs.
   // The requester rdata is a pass-through of s_rdata only on a real slave
   // completion. A forced completion returns zero. The non-granted side
   // always sees zero.
   always_comb begin
      state_next = state;
      pick_m1    = 1'b0;
      start      = 1'b0;
      done       = 1'b0;
      forced     = 1'b0;
      s_valid    = 1'b0;
      m0_ready   = 1'b0;
      m1_ready   = 1'b0;
      m0_rdata   = '0;
      m1_rdata   = '0;

      case (state)
         IDLE: begin
            // A lone requester always wins. On a tie, the pointer decides.
            pick_m1 = m1_valid && (!m0_valid || prio_m1);
            if (m0_valid || m1_valid) begin
               start      = 1'b1;
               state_next = BUSY;
            end
         end

         BUSY: begin
            s_valid = 1'b1;
            // A slave answer in the last allowed cycle is a normal completion.
            done    = s_ready || (cycle_cnt == CNT_LAST);
            forced  = !s_ready && (cycle_cnt == CNT_LAST);
            if (done) begin
               state_next = IDLE;
               m0_ready   = !grant_m1;
               m1_ready   = grant_m1;
               if (s_ready) begin
                  if (grant_m1) begin
                     m1_rdata = s_rdata;
                  end else begin
                     m0_rdata = s_rdata;
                  end
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Grant bookkeeping, registered request fields, watchdog counter and
   // sticky error. The request fields are captured only when a grant is made.
   // They therefore hold steady for the whole BUSY period, whatever the
   // requesters do afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_m1    <= 1'b0;
         prio_m1     <= 1'b0;
         cycle_cnt   <= '0;
         s_addr      <= '0;
         s_wdata     <= '0;
         s_wstrb     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (start) begin
            grant_m1  <= pick_m1;
            prio_m1   <= !pick_m1;
            cycle_cnt <= '0;
            s_addr    <= pick_m1 ? m1_addr  : m0_addr;
            s_wdata   <= pick_m1 ? m1_wdata : m0_wdata;
            s_wstrb   <= pick_m1 ? m1_wstrb : m0_wstrb;
         end else if (state == BUSY && !done) begin
            cycle_cnt <= cycle_cnt + 16'd1;
         end

         if (forced) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iob_mem_arbiter
//
// Purpose:
//    Self-checking bench for iob_mem_arbiter (TIMEOUT = 8). Each scenario task
//    drives requesters and pushes the completion it expects onto a scoreboard
//    queue. A monitor pops that queue whenever a ready pulse appears.
//    A small slave model answers after a programmable number of BUSY cycles.
// ---------------------------------------------------------------------------
module tb_iob_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk;
   logic          reset;
   logic          m0_valid, m1_valid;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [3:0]    m0_wstrb, m1_wstrb;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          m0_ready, m1_ready;
   logic          s_valid;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic [3:0]    s_wstrb;
   logic [DW-1:0] s_rdata;
   logic          s_ready;
   logic          timeout_err;

   typedef struct {
      logic          m1;
      logic [DW-1:0] rdata;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [3:0]    wstrb;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fails  = 0;

   // Slave model controls: answer in the slave_lat-th BUSY cycle (0 = never),
   // or answer spuriously while idle when idle_poke is set.
   int busy_cnt  = 0;
   int slave_lat = 0;
   bit idle_poke = 0;

   iob_mem_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .m0_valid   (m0_valid),
      .m0_addr    (m0_addr),
      .m0_wdata   (m0_wdata),
      .m0_wstrb   (m0_wstrb),
      .m0_rdata   (m0_rdata),
      .m0_ready   (m0_ready),
      .m1_valid   (m1_valid),
      .m1_addr    (m1_addr),
      .m1_wdata   (m1_wdata),
      .m1_wstrb   (m1_wstrb),
      .m1_rdata   (m1_rdata),
      .m1_ready   (m1_ready),
      .s_valid    (s_valid),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_wstrb    (s_wstrb),
      .s_rdata    (s_rdata),
      .s_ready    (s_ready),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents as seen by the slave model.
   function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
      if (a == 32'h100) return 32'hCAFEF00D;
      return a * 32'h9E3779B1 + 32'h1357;
   endfunction

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Slave model. While no answer is due, it puts junk on s_rdata so that a
   // forced completion that leaks s_rdata shows up.
   initial begin
      s_ready = 1'b0;
      s_rdata = '0;
      forever begin
         tick();
         s_ready = 1'b0;
         s_rdata = 32'hDEADBEEF;
         if (s_valid === 1'b1) busy_cnt++;
         else busy_cnt = 0;
         if (idle_poke && s_valid !== 1'b1) begin
            s_ready = 1'b1;
            s_rdata = 32'h0BADF00D;
         end else if (slave_lat != 0 && busy_cnt == slave_lat) begin
            s_ready = 1'b1;
            s_rdata = slave_data(s_addr);
         end
      end
   end

   // Scoreboard monitor: every ready pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (reset === 1'b0 && (m0_ready === 1'b1 || m1_ready === 1'b1)) begin
         exp_t e;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fails++;
            $display("[TB] FAIL sb_unexpected: got ready m0=%0b m1=%0b, expected no pulse", m0_ready, m1_ready);
         end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (m0_ready !== !e.m1 || m1_ready !== e.m1) begin
               n_fails++;
               $display("[TB] FAIL sb_owner: got m0_ready=%0b m1_ready=%0b, expected m1=%0b", m0_ready, m1_ready, e.m1);
            end
            n_checks++;
            if ((e.m1 ? m1_rdata : m0_rdata) !== e.rdata) begin
               n_fails++;
               $display("[TB] FAIL sb_rdata: got %h, expected %h", e.m1 ? m1_rdata : m0_rdata, e.rdata);
            end
            n_checks++;
            if ((e.m1 ? m0_rdata : m1_rdata) !== '0) begin
               n_fails++;
               $display("[TB] FAIL sb_other_rdata: got %h, expected 0", e.m1 ? m0_rdata : m1_rdata);
            end
            n_checks++;
            if (s_addr !== e.addr || s_wdata !== e.wdata || s_wstrb !== e.wstrb) begin
               n_fails++;
               $display("[TB] FAIL sb_fields: got %h/%h/%h, expected %h/%h/%h", s_addr, s_wdata, s_wstrb, e.addr, e.wdata, e.wstrb);
            end
         end
      end
   end

   // Hard stop in case something loops far beyond every scenario budget.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, expected end within 200000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

   // Synchronous reset with idle inputs: everything must come up cleared.
   task automatic test_reset();
      reset    = 1'b1;
      m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      tick();
      tick();
      #1;
      n_checks++;
      if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL reset_ctrl: got s_valid=%b m0_ready=%b m1_ready=%b, expected 0/0/0", s_valid, m0_ready, m1_ready);
      end
      n_checks++;
      if (timeout_err !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL reset_err: got %b, expected 0", timeout_err);
      end
      n_checks++;
      if (s_addr !== '0 || s_wdata !== '0 || s_wstrb !== '0) begin
         n_fails++;
         $display("[TB] FAIL reset_fields: got %h/%h/%h, expected 0/0/0", s_addr, s_wdata, s_wstrb);
      end
      tick();
      reset = 1'b0;
   endtask

   // m0 read of 0x100 answered in the 3rd BUSY cycle.
   task automatic test_single_read();
      int  pulses = 0;
      int  pulse_cyc = -1;
      bit  m1_seen = 0;
      slave_lat = 3;
      tick();
      m0_valid = 1'b1; m0_addr = 32'h100; m0_wdata = '0; m0_wstrb = 4'h0;
      exp_q.push_back('{1'b0, 32'hCAFEF00D, 32'h100, 32'h0, 4'h0});
      #1;
      n_checks++;
      if (s_valid !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL read_idle: got s_valid=%b, expected 0", s_valid);
      end
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (pulses > 0) m0_valid = 1'b0;
         #1;
         if (c == 1) begin
            n_checks++;
            if (s_valid !== 1'b1) begin
               n_fails++;
               $display("[TB] FAIL read_latency: got s_valid=%b, expected 1", s_valid);
            end
         end
         if (m1_ready !== 1'b0) m1_seen = 1;
         if (m0_ready === 1'b1) begin
            pulses++;
            if (pulse_cyc < 0) pulse_cyc = c;
         end
      end
      n_checks++;
      if (pulses != 1 || pulse_cyc != 3) begin
         n_fails++;
         $display("[TB] FAIL read_pulse: got %0d pulses at cycle %0d, expected 1 at cycle 3", pulses, pulse_cyc);
      end
      n_checks++;
      if (m1_seen) begin
         n_fails++;
         $display("[TB] FAIL read_m1_quiet: got m1_ready high, expected 0");
      end
   endtask

   // Both requesters held continuously after reset: m0,m1,m0,m1,...
   // with exactly one IDLE cycle between transactions.
   task automatic test_round_robin();
      int   pulses = 0;
      int   last_cyc = -1;
      bit   order_ok = 1;
      bit   gap_ok = 1;
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      slave_lat = 1;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) exp_q.push_back('{1'b0, slave_data(32'h200), 32'h200, 32'h0, 4'h0});
         else            exp_q.push_back('{1'b1, slave_data(32'h300), 32'h300, 32'h0, 4'h0});
      end
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (pulses >= 6) begin
            m0_valid = 1'b0; m1_valid = 1'b0;
         end else begin
            m0_valid = 1'b1; m0_addr = 32'h200; m0_wdata = '0; m0_wstrb = '0;
            m1_valid = 1'b1; m1_addr = 32'h300; m1_wdata = '0; m1_wstrb = '0;
         end
         #1;
         if (c <= 12 && s_valid !== ((c % 2 == 0) ? 1'b1 : 1'b0)) gap_ok = 0;
         if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            if (m1_ready !== ((pulses % 2 == 1) ? 1'b1 : 1'b0)) order_ok = 0;
            pulses++;
            last_cyc = c;
         end
      end
      n_checks++;
      if (!order_ok) begin
         n_fails++;
         $display("[TB] FAIL rr_order: got wrong grant order, expected m0,m1,m0,m1,m0,m1");
      end
      n_checks++;
      if (!gap_ok) begin
         n_fails++;
         $display("[TB] FAIL rr_idle_gap: got s_valid pattern off, expected alternating idle/busy");
      end
      n_checks++;
      if (pulses != 6 || last_cyc != 12) begin
         n_fails++;
         $display("[TB] FAIL rr_count: got %0d pulses, last at %0d, expected 6, last at 12", pulses, last_cyc);
      end
   endtask

   // m1 write while both requesters scramble their fields: the slave-side
   // fields must hold the granted values. m1 is alone, so it wins even though
   // it was granted last.
   task automatic test_write_hold();
      int pulses = 0;
      int pulse_cyc = -1;
      slave_lat = 4;
      tick();
      m1_valid = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_wstrb = 4'hF;
      exp_q.push_back('{1'b1, slave_data(32'h20), 32'h20, 32'h12345678, 4'hF});
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (pulses > 0) m1_valid = 1'b0;
         m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
         m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
         #1;
         if (s_valid === 1'b1) begin
            n_checks++;
            if (s_addr !== 32'h20 || s_wdata !== 32'h12345678 || s_wstrb !== 4'hF) begin
               n_fails++;
               $display("[TB] FAIL hold_fields: got %h/%h/%h, expected 00000020/12345678/f", s_addr, s_wdata, s_wstrb);
            end
         end
         if (m1_ready === 1'b1) begin
            pulses++;
            if (pulse_cyc < 0) pulse_cyc = c;
         end
      end
      n_checks++;
      if (pulses != 1 || pulse_cyc != 4) begin
         n_fails++;
         $display("[TB] FAIL hold_pulse: got %0d pulses at cycle %0d, expected 1 at cycle 4", pulses, pulse_cyc);
      end
      m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
   endtask

   // s_ready pulsing while IDLE must be ignored.
   task automatic test_idle_ready_ignored();
      bit quiet = 1;
      idle_poke = 1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         #1;
         if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || s_valid !== 1'b0) quiet = 0;
      end
      idle_poke = 0;
      n_checks++;
      if (!quiet) begin
         n_fails++;
         $display("[TB] FAIL idle_ready: got ready/s_valid activity, expected none");
      end
   endtask

   // Slave answers in the very cycle the watchdog would fire: normal completion.
   task automatic test_timeout_boundary();
      int pulses = 0;
      int pulse_cyc = -1;
      slave_lat = TO;
      tick();
      m0_valid = 1'b1; m0_addr = 32'h44;
      exp_q.push_back('{1'b0, slave_data(32'h44), 32'h44, 32'h0, 4'h0});
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (pulses > 0) m0_valid = 1'b0;
         #1;
         if (m0_ready === 1'b1) begin
            pulses++;
            if (pulse_cyc < 0) pulse_cyc = c;
         end
      end
      n_checks++;
      if (pulses != 1 || pulse_cyc != TO) begin
         n_fails++;
         $display("[TB] FAIL edge_pulse: got %0d pulses at cycle %0d, expected 1 at cycle %0d", pulses, pulse_cyc, TO);
      end
      n_checks++;
      if (timeout_err !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL edge_err: got %b, expected 0", timeout_err);
      end
   endtask

   // Silent slave: forced completion in the 8th s_valid cycle with rdata 0.
   // The sticky flag then survives a later good transaction.
   task automatic test_timeout();
      int pulses = 0;
      int pulse_cyc = -1;
      int high_cnt = 0;
      bit err_kept = 1;
      slave_lat = 0;
      tick();
      m0_valid = 1'b1; m0_addr = 32'h48;
      exp_q.push_back('{1'b0, 32'h0, 32'h48, 32'h0, 4'h0});
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (pulses > 0) m0_valid = 1'b0;
         #1;
         if (s_valid === 1'b1) high_cnt++;
         if (m0_ready === 1'b1) begin
            pulses++;
            if (pulse_cyc < 0) pulse_cyc = high_cnt;
         end
      end
      n_checks++;
      if (pulses != 1 || pulse_cyc != TO || high_cnt != TO) begin
         n_fails++;
         $display("[TB] FAIL to_pulse: got %0d pulses in busy cycle %0d of %0d, expected 1 in cycle %0d of %0d", pulses, pulse_cyc, high_cnt, TO, TO);
      end
      n_checks++;
      if (timeout_err !== 1'b1) begin
         n_fails++;
         $display("[TB] FAIL to_err_set: got %b, expected 1", timeout_err);
      end
      slave_lat = 2;
      pulses = 0;
      tick();
      m1_valid = 1'b1; m1_addr = 32'h80;
      exp_q.push_back('{1'b1, slave_data(32'h80), 32'h80, 32'h0, 4'h0});
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (pulses > 0) m1_valid = 1'b0;
         #1;
         if (timeout_err !== 1'b1) err_kept = 0;
         if (m1_ready === 1'b1) pulses++;
      end
      n_checks++;
      if (!err_kept || pulses != 1) begin
         n_fails++;
         $display("[TB] FAIL to_err_sticky: got err_kept=%0b pulses=%0d, expected 1/1", err_kept, pulses);
      end
   endtask

   // Reset in the 2nd BUSY cycle of an m0 transaction: the transaction is
   // dropped silently and priority returns to m0.
   task automatic test_reset_mid_busy();
      bit quiet = 1;
      int pulses = 0;
      bit first_m1 = 0;
      bit m0_done = 0;
      bit m1_done = 0;
      slave_lat = 0;
      tick();
      m0_valid = 1'b1; m0_addr = 32'h60;
      tick();
      #1;
      if (m0_ready !== 1'b0 || m1_ready !== 1'b0) quiet = 0;
      tick();
      reset = 1'b1; m0_valid = 1'b0;
      #1;
      if (m0_ready !== 1'b0 || m1_ready !== 1'b0) quiet = 0;
      n_checks++;
      if (s_valid !== 1'b1) begin
         n_fails++;
         $display("[TB] FAIL rst_sync: got s_valid=%b in reset cycle, expected 1", s_valid);
      end
      tick();
      reset = 1'b0;
      #1;
      if (m0_ready !== 1'b0 || m1_ready !== 1'b0) quiet = 0;
      n_checks++;
      if (s_valid !== 1'b0 || timeout_err !== 1'b0 || s_addr !== '0) begin
         n_fails++;
         $display("[TB] FAIL rst_mid_state: got s_valid=%b err=%b addr=%h, expected 0/0/0", s_valid, timeout_err, s_addr);
      end
      n_checks++;
      if (!quiet) begin
         n_fails++;
         $display("[TB] FAIL rst_no_pulse: got a ready pulse, expected none");
      end
      slave_lat = 1;
      exp_q.push_back('{1'b0, slave_data(32'h70), 32'h70, 32'h0, 4'h0});
      exp_q.push_back('{1'b1, slave_data(32'h74), 32'h74, 32'h0, 4'h0});
      m0_addr = 32'h70; m1_addr = 32'h74;
      for (int c = 1; c <= 8; c++) begin
         tick();
         m0_valid = !m0_done;
         m1_valid = !m1_done;
         #1;
         if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            if (pulses == 0) first_m1 = (m1_ready === 1'b1);
            if (m0_ready === 1'b1) m0_done = 1;
            if (m1_ready === 1'b1) m1_done = 1;
            pulses++;
         end
      end
      m0_valid = 1'b0; m1_valid = 1'b0;
      n_checks++;
      if (pulses != 2 || first_m1) begin
         n_fails++;
         $display("[TB] FAIL rst_prio: got %0d pulses first_m1=%0b, expected 2 with m0 first", pulses, first_m1);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_hold();
      test_idle_ready_ignored();
      test_timeout_boundary();
      test_timeout();
      test_reset_mid_busy();
      tick();
      tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("[TB] FAIL sb_leftover: got %0d pending completions, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
